// File: rtl/uart_mem_dump_if.sv
// Bus bundle for the UART memory dumper: host request/status, memory read
// port and the serial line. The dumper uses the slave view; the environment
// (host plus memory) uses the master view.
interface uart_mem_dump_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [ADDR_W-1:0] base_adr;
    logic [ADDR_W:0]   word_cnt;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_dat;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output start, base_adr, word_cnt, mem_dat,
        input  mem_rd_en, mem_adr, tx, busy, done
    );

    modport slave (
        input  start, base_adr, word_cnt, mem_dat,
        output mem_rd_en, mem_adr, tx, busy, done
    );
endinterface

// File: rtl/uart_mem_dump.sv
// UART transmit-side memory dumper. On an accepted start it reads word_cnt
// consecutive 32-bit words (address wraps modulo 2^ADDR_W) and sends each one
// little-endian as four 8N1 frames, back to back, with only the two-cycle
// fetch/latch gap between words.
module uart_mem_dump #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    uart_mem_dump_if.slave   bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W:0]   r_remain;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_shift;
    logic              r_done;
    logic              w_done_next;
    logic              w_tx;
    logic              w_bit_end;
    logic              w_accept;
    logic              w_more_words;

    // A start is only taken in IDLE, and never in the cycle that shows done.
    assign w_accept     = (r_state == S_IDLE) && bus.start && !r_done;
    assign w_bit_end    = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_more_words = (r_remain > (ADDR_W + 1)'(1));

    // State register; reset drops straight to IDLE even mid-frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state decode plus the serial line level for the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_tx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.word_cnt != '0) w_state_next = S_FETCH;
                    else                    w_done_next  = 1'b1;
                end
            end
            S_FETCH: w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_START;
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte_idx != 2'd3) begin
                        w_state_next = S_START;
                    end else if (w_more_words) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: address/word counters, bit timer, bit/byte indices, shift word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_remain   <= '0;
            r_adr      <= '0;
            r_shift    <= '0;
        end else begin
            if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP))
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
            else
                r_clk_cnt <= '0;

            case (r_state)
                S_IDLE: begin
                    // The address only moves when a read will follow, so
                    // mem_adr keeps its last read address otherwise.
                    if (w_accept && (bus.word_cnt != '0)) begin
                        r_adr    <= bus.base_adr;
                        r_remain <= bus.word_cnt;
                    end
                end
                S_LATCH: begin
                    r_shift    <= bus.mem_dat;
                    r_byte_idx <= '0;
                    r_bit_idx  <= '0;
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_byte_idx != 2'd3) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end else if (w_more_words) begin
                            r_remain <= r_remain - 1'b1;
                            r_adr    <= r_adr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rd_en = (r_state == S_FETCH);
    assign bus.mem_adr   = r_adr;
    assign bus.tx        = w_tx;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
endmodule

// File: tb/tb_uart_mem_dump.sv
// Self-checking bench for uart_mem_dump: memory model, serial receiver and
// read monitor compare against scoreboard queues filled by the directed steps.
module tb_uart_mem_dump;
    localparam int CPB      = 4;
    localparam int AW       = 14;
    localparam int WORD_CYC = 2 + 40 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [31:0]   mem [0:(1 << AW) - 1];
    logic [AW-1:0] q_adr [$];
    logic [7:0]    q_byte [$];
    int            q_start_t [$];

    uart_mem_dump_if #(.ADDR_W(AW)) bus ();

    uart_mem_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory: data valid the cycle after the read strobe.
    always @(posedge clk) if (bus.mem_rd_en === 1'b1) bus.mem_dat <= mem[bus.mem_adr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read monitor: every strobe must match the next expected address.
    always @(negedge clk) begin
        if (!rst && bus.mem_rd_en === 1'b1) begin
            check("rd_expected", q_adr.size() != 0, 1);
            if (q_adr.size() != 0) check("rd_adr", bus.mem_adr, q_adr.pop_front());
        end
    end

    // Serial receiver: samples the middle of each bit, cycle-exact framing.
    int         rx_cnt = -1;
    int         rx_bit;
    logic       prev_tx = 1'b1;
    logic [7:0] rx_byte = '0;
    always @(negedge clk) begin
        if (rst) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (prev_tx && bus.tx === 1'b0) begin
                rx_cnt = 0;
                q_start_t.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_bit = rx_cnt / CPB;
                if (rx_bit == 0) begin
                    check("rx_start_bit", bus.tx, 0);
                end else if (rx_bit <= 8) begin
                    rx_byte[rx_bit-1] = bus.tx;
                end else begin
                    check("rx_stop_bit", bus.tx, 1);
                    check("rx_expected", q_byte.size() != 0, 1);
                    if (q_byte.size() != 0) check("rx_byte", rx_byte, q_byte.pop_front());
                    rx_cnt = -1;
                end
            end
        end
        prev_tx = bus.tx;
    end

    task automatic push_word(input logic [AW-1:0] adr, input logic [31:0] dat);
        mem[adr] = dat;
        q_adr.push_back(adr);
        for (int k = 0; k < 4; k++) q_byte.push_back(dat[8*k +: 8]);
    endtask

    // Called at a negedge; returns at the negedge of the FETCH cycle.
    task automatic pulse_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        bus.start    = 1'b1;
        bus.base_adr = base;
        bus.word_cnt = cnt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int t_done);
        t_done = -1;
        for (int i = 0; i < limit; i++) begin
            if (bus.done === 1'b1) begin
                t_done = cyc;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", t_done >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_f;
        int t_d;
        bus.start    = 1'b0;
        bus.base_adr = '0;
        bus.word_cnt = '0;
        bus.mem_dat  = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.tx, bus.busy, bus.done, bus.mem_rd_en}, 4'b1000);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {bus.tx, bus.busy, bus.done, bus.mem_rd_en}, 4'b1000);
        end
        check("idle_mem_adr", bus.mem_adr, 0);

        // Single word.
        push_word(14'h0010, 32'h12345678);
        q_start_t.delete();
        pulse_start(14'h0010, 15'd1);
        t_f = cyc;
        check("s1_fetch_state", {bus.busy, bus.mem_rd_en, bus.tx}, 3'b111);
        check("s1_fetch_adr", bus.mem_adr, 14'h0010);
        @(negedge clk);
        check("s1_latch_state", {bus.busy, bus.mem_rd_en, bus.tx}, 3'b101);
        @(negedge clk);
        check("s1_start_bit", bus.tx, 0);
        wait_done(1000, t_d);
        check("s1_length", t_d - t_f, WORD_CYC);
        check("s1_done_busy", bus.busy, 0);
        check("s1_bytes_left", q_byte.size(), 0);
        check("s1_frames", q_start_t.size(), 4);
        check("s1_first_frame", q_start_t[0] - t_f, 2);
        @(negedge clk);
        check("s1_done_pulse", bus.done, 0);

        // Wrap across the top address, two words.
        push_word(14'h3FFF, 32'hA1B2C3D4);
        push_word(14'h0000, 32'h0BADF00D);
        q_start_t.delete();
        pulse_start(14'h3FFF, 15'd2);
        t_f = cyc;
        wait_done(2000, t_d);
        check("wrap_length", t_d - t_f, 2 * WORD_CYC);
        check("wrap_bytes_left", q_byte.size(), 0);
        check("wrap_reads_left", q_adr.size(), 0);
        check("wrap_frames", q_start_t.size(), 8);
        for (int i = 1; i < 8; i++)
            check("wrap_frame_spacing", q_start_t[i] - q_start_t[i-1], (i == 4) ? 42 : 40);
        @(negedge clk);

        // Zero-length request.
        pulse_start(14'h0123, 15'd0);
        check("zero_done", {bus.done, bus.busy, bus.tx, bus.mem_rd_en}, 4'b1010);
        @(negedge clk);
        check("zero_done_clear", {bus.done, bus.busy, bus.tx}, 3'b001);
        check("zero_mem_adr_held", bus.mem_adr, 14'h0000);

        // Start while busy is ignored.
        push_word(14'h0020, 32'hCAFEBABE);
        pulse_start(14'h0020, 15'd1);
        t_f = cyc;
        repeat (30) @(negedge clk);
        mem[14'h0030] = 32'hDEADDEAD;
        bus.start     = 1'b1;
        bus.base_adr  = 14'h0030;
        bus.word_cnt  = 15'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ign_busy", bus.busy, 1);
        wait_done(1000, t_d);
        check("busy_ign_length", t_d - t_f, WORD_CYC);
        check("busy_ign_bytes_left", q_byte.size(), 0);

        // Start coincident with done is ignored; held one more cycle it is taken.
        push_word(14'h0040, 32'h0F1E2D3C);
        bus.start    = 1'b1;
        bus.base_adr = 14'h0040;
        bus.word_cnt = 15'd1;
        @(negedge clk);
        check("done_coincident_ignored", {bus.busy, bus.done}, 2'b00);
        @(negedge clk);
        bus.start = 1'b0;
        t_f = cyc;
        check("after_done_accept", {bus.busy, bus.mem_rd_en}, 2'b11);
        check("after_done_adr", bus.mem_adr, 14'h0040);
        wait_done(1000, t_d);
        check("after_done_length", t_d - t_f, WORD_CYC);
        check("after_done_bytes_left", q_byte.size(), 0);
        @(negedge clk);

        // Reset in the middle of byte 2's data bits.
        mem[14'h0050] = 32'h11223344;
        mem[14'h0051] = 32'h55667788;
        q_adr.push_back(14'h0050);
        q_byte.push_back(8'h44);
        q_byte.push_back(8'h33);
        pulse_start(14'h0050, 15'd2);
        t_f = cyc;
        while (cyc < t_f + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {bus.tx, bus.busy, bus.done, bus.mem_rd_en}, 4'b1000);
        check("rst_mid_adr", bus.mem_adr, 0);
        check("rst_mid_bytes_left", q_byte.size(), 0);
        check("rst_mid_reads_left", q_adr.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_mid_idle", {bus.tx, bus.busy, bus.mem_rd_en}, 3'b100);
        end

        // A full frame after reset.
        push_word(14'h0060, 32'h89ABCDEF);
        pulse_start(14'h0060, 15'd1);
        t_f = cyc;
        check("post_rst_fetch", {bus.busy, bus.mem_rd_en}, 2'b11);
        wait_done(1000, t_d);
        check("post_rst_length", t_d - t_f, WORD_CYC);
        check("post_rst_bytes_left", q_byte.size(), 0);
        check("post_rst_reads_left", q_adr.size(), 0);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_mem_dump.md
# uart_mem_dump

UART transmit-side memory dumper: on a start pulse it reads a contiguous range of 32-bit words from a synchronous-read memory port and sends them over the `tx` line as 8N1 serial bytes. It is the sending counterpart of the UART program loader, which receives bytes on `rx` and writes them into instruction/data memory. It sits beside the loader in `cpu_top`, shares the UART clock domain, and lets the host read memory back for verification.

## Interface
Parameters:
- `CLKS_PER_BIT`, 87: clock cycles per serial bit (10 MHz / 115200 baud). Must be ≥ 2.
- `ADDR_W`, 14: word-address width of the memory read port.

Ports:
- `clk` input 1: single clock for the whole block; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request pulse; sampled only while idle.
- `base_adr` input ADDR_W: first word address; sampled with `start`.
- `word_cnt` input ADDR_W+1: number of words to send; sampled with `start`.
- `mem_rd_en` output 1: memory read strobe.
- `mem_adr` output ADDR_W: memory word address.
- `mem_dat` input 32: read data, valid the cycle after `mem_rd_en`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: `tx`=1. On `start`=1, latch `base_adr` into the address counter and `word_cnt` into the remaining-word counter.
  - If `word_cnt`≠0, go to FETCH.
  - If `word_cnt`=0, pulse `done` next cycle with no transmission and no read.
- FETCH: one cycle; `mem_rd_en`=1 and `mem_adr`=current address. Go to LATCH.
- LATCH: one cycle; capture `mem_dat` into a 32-bit shift word; clear byte index to 0. Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits LSB-first, each held CLKS_PER_BIT cycles. Byte k is word bits [8k+7:8k], so the word is sent little-endian.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
  - byte index < 3: increment the index and go straight to START (no gap).
  - else, remaining words > 1: decrement the remaining count, increment the address, go to FETCH.
  - else: return to IDLE and pulse `done`.
- Address arithmetic is modulo 2^ADDR_W: a range crossing the top address wraps to 0.
- `start` is ignored while `busy`=1. A `start` in the same cycle as `done` is also ignored. `start` is accepted from the cycle after `done`.
- `mem_rd_en` is 0 outside FETCH. `mem_adr` holds its last value when not reading.
- `rst` overrides everything, including mid-byte: on the next edge `tx`=1, IDLE, counters cleared. No partial stop bit is emitted.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `mem_rd_en`=0, `mem_adr`=0.
- `start` accepted at edge 0. Edge 1: FETCH, `busy`=1. Edge 2: LATCH. Edge 3: `tx` falls (start bit).
- One byte = 10×CLKS_PER_BIT cycles. One word = 2 + 40×CLKS_PER_BIT cycles.
- Total length for N≥1 words is N×(2+40×CLKS_PER_BIT) cycles from the first FETCH to the end of the last stop bit. In the following cycle, `done`=1 and `busy`=0 together.
- Between words, `tx` stays high for exactly 2 extra cycles (FETCH + LATCH) after the stop bit.
- `word_cnt`=0: `done`=1 on edge 1; `busy` never rises.

## Test plan
- Reset then idle with CLKS_PER_BIT=4: `tx`=1, `busy`=0, `done`=0, `mem_rd_en`=0 held for 50 cycles.
- Single word, base=0x0010, cnt=1, memory[0x10]=0x12345678, CLKS_PER_BIT=4 → one read at 0x0010; bytes 0x78,0x56,0x34,0x12 LSB-first, 4 cycles/bit; `done` exactly 162 cycles after the FETCH cycle.
- Wrap: base=0x3FFF, cnt=2, ADDR_W=14 → reads at 0x3FFF then 0x0000; 8 bytes sent; exactly 2 idle-high cycles between word frames.
- `word_cnt`=0 → `done` one cycle after `start`; no `mem_rd_en`, `tx` stays high.
- `start` pulses during transmission and coincident with `done` → ignored. A `start` one cycle after `done` begins a new dump.
- `rst` asserted in the middle of DATA of byte 2 → `tx`=1 and `busy`=0 next cycle, no further reads. A subsequent `start` sends a full correct frame.
